// File: rtl/bus_split_pkg.sv
// bus_split_pkg: shared state encoding, default geometry and lane-count clamp for the bus split unpacker.
package bus_split_pkg;
  localparam int LANE_W_DEF = 2;
  localparam int LANES_DEF = 4;
  typedef enum logic {IDLE, SHIFT} state_t;
  function automatic int clamp_lanes(input int l, input int n = LANES_DEF);
    return (l == 0 || l > n) ? n : l;
  endfunction
endpackage

// File: rtl/bus_split_lane_mux.sv
// bus_split_lane_mux: selects one lane of the held word, zero when idle; optional parity under BUS_SPLIT_PARITY_EN.
module bus_split_lane_mux #(
  parameter int LANE_W = 2,
  parameter int LANES = 4,
  parameter int IDX_W = $clog2(LANES)
) (
  input  logic                    en,
  input  logic [LANES*LANE_W-1:0] word,
  input  logic [IDX_W-1:0]        idx,
`ifdef BUS_SPLIT_PARITY_EN
  output logic [LANE_W-1:0]       data,
  output logic                    par
`else
  output logic [LANE_W-1:0]       data
`endif
);
  assign data = en ? word[idx*LANE_W +: LANE_W] : '0;
`ifdef BUS_SPLIT_PARITY_EN
  assign par = ^data;
`endif
endmodule

// File: rtl/bus_split_unpacker.sv
// bus_split_unpacker: re-emits a merged word as LSB-first lane beats over valid/ready; out_par only with BUS_SPLIT_PARITY_EN.
module bus_split_unpacker
  import bus_split_pkg::*;
#(
  parameter int LANE_W = LANE_W_DEF,
  parameter int LANES = LANES_DEF,
  localparam int IDX_W = $clog2(LANES)
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [LANES*LANE_W-1:0] in_data,
  input  logic [IDX_W:0]          in_lanes,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [LANE_W-1:0]       out_data,
  output logic [IDX_W-1:0]        out_idx,
`ifdef BUS_SPLIT_PARITY_EN
  output logic                    out_last,
  output logic                    out_par
`else
  output logic                    out_last
`endif
);
  state_t                  state, state_n;
  logic [LANES*LANE_W-1:0] hold, hold_n;
  logic [IDX_W-1:0]        idx, idx_n, last, last_n;
  logic                    accept, fire, done;
  assign out_valid = state == SHIFT;
  assign out_idx = idx;
  assign out_last = out_valid && idx == last;
  assign fire = out_valid && out_ready;
  assign done = fire && out_last;
  // gated by reset so the upstream never sees ready while the word register is being cleared
  assign in_ready = !reset && (state == IDLE || done);
  assign accept = in_valid && in_ready;
  always_comb begin
    state_n = accept ? SHIFT : done ? IDLE : state;
    hold_n = accept ? in_data : hold;
    last_n = accept ? IDX_W'(clamp_lanes(int'(in_lanes), LANES) - 1) : last;
    idx_n = (accept || done) ? '0 : fire ? idx + 1'b1 : idx;
  end
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
      hold <= '0;
      idx <= '0;
      last <= '0;
    end else begin
      state <= state_n;
      hold <= hold_n;
      idx <= idx_n;
      last <= last_n;
    end
  end
  bus_split_lane_mux #(.LANE_W(LANE_W), .LANES(LANES), .IDX_W(IDX_W)) u_mux (
    .en(out_valid),
    .word(hold),
    .idx(idx),
`ifdef BUS_SPLIT_PARITY_EN
    .data(out_data),
    .par(out_par)
`else
    .data(out_data)
`endif
  );
endmodule

// File: tb/tb_bus_split_unpacker.sv
// tb_bus_split_unpacker: directed self-checking bench for bus_split_unpacker (LANE_W=2, LANES=4).
module tb_bus_split_unpacker;
  logic       clk = 0;
  logic       reset = 1;
  logic       in_valid = 0;
  logic       in_ready;
  logic [7:0] in_data = '0;
  logic [2:0] in_lanes = '0;
  logic       out_valid;
  logic       out_ready = 0;
  logic [1:0] out_data;
  logic [1:0] out_idx;
  logic       out_last;
`ifdef BUS_SPLIT_PARITY_EN
  logic       out_par;
`endif
  int errors = 0;
  int checks = 0;

  bus_split_unpacker dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .in_data(in_data), .in_lanes(in_lanes), .out_valid(out_valid),
    .out_ready(out_ready), .out_data(out_data), .out_idx(out_idx),
`ifdef BUS_SPLIT_PARITY_EN
    .out_last(out_last), .out_par(out_par)
`else
    .out_last(out_last)
`endif
  );

  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic beat(input string tag, input logic [7:0] w, input int i, input logic last, input logic rdy);
    logic [1:0] lane;
    lane = w[i*2 +: 2];
    chk({tag, "_valid"}, out_valid, 1);
    chk({tag, "_idx"}, out_idx, i);
    chk({tag, "_data"}, out_data, lane);
    chk({tag, "_last"}, out_last, last);
    chk({tag, "_in_ready"}, in_ready, rdy);
`ifdef BUS_SPLIT_PARITY_EN
    chk({tag, "_par"}, out_par, ^lane);
`endif
  endtask

  task automatic idle_chk(input string tag);
    chk({tag, "_valid"}, out_valid, 0);
    chk({tag, "_in_ready"}, in_ready, 1);
    chk({tag, "_data"}, out_data, 0);
`ifdef BUS_SPLIT_PARITY_EN
    chk({tag, "_par"}, out_par, 0);
`endif
  endtask

  task automatic word(input string tag, input logic [7:0] w, input logic [2:0] l, input int n);
    in_data = w;
    in_lanes = l;
    in_valid = 1;
    out_ready = 1;
    #1 chk({tag, "_accept"}, in_ready, 1);
    tick;
    in_valid = 0;
    for (int i = 0; i < n; i++) begin
      #1 beat(tag, w, i, i == n - 1, i == n - 1);
      tick;
    end
    #1 idle_chk({tag, "_end"});
  endtask

  initial begin
    int xfers;
    int cyc;
    int ei;
    logic rdy;
    #1;
    chk("rst_valid", out_valid, 0);
    chk("rst_in_ready", in_ready, 0);
    chk("rst_idx", out_idx, 0);
    chk("rst_last", out_last, 0);
    chk("rst_data", out_data, 0);
    @(negedge clk);
    reset = 0;
    #1 idle_chk("post_rst");
    @(negedge clk);

    word("full", 8'hE4, 3'd4, 4);

    in_data = 8'hE4;
    in_lanes = 3'd4;
    in_valid = 1;
    out_ready = 1;
    #1 chk("b2b_accept0", in_ready, 1);
    tick;
    for (int i = 0; i < 4; i++) begin
      if (i == 3) in_data = 8'h1B;
      #1 beat("b2b_w0", 8'hE4, i, i == 3, i == 3);
      tick;
    end
    in_valid = 0;
    for (int i = 0; i < 4; i++) begin
      #1 beat("b2b_w1", 8'h1B, i, i == 3, i == 3);
      tick;
    end
    #1 idle_chk("b2b_end");

    word("lanes2", 8'hE4, 3'd2, 2);
    word("lanes0", 8'hE4, 3'd0, 4);
    word("lanes1", 8'hE7, 3'd1, 1);
    word("lanes5", 8'h9C, 3'd5, 4);

    in_data = 8'hE4;
    in_lanes = 3'd4;
    in_valid = 1;
    out_ready = 1;
    tick;
    in_valid = 0;
    xfers = 0;
    cyc = 0;
    ei = 0;
    while (xfers < 4 && cyc < 40) begin
      rdy = (cyc % 3) == 0;
      out_ready = rdy;
      #1 beat("bp", 8'hE4, ei, ei == 3, rdy && ei == 3);
      tick;
      if (rdy) begin
        xfers++;
        ei++;
      end
      cyc++;
    end
    chk("bp_xfers", xfers, 4);
    #1 idle_chk("bp_end");

    in_data = 8'h1B;
    in_lanes = 3'd4;
    in_valid = 1;
    out_ready = 1;
    tick;
    in_valid = 0;
    for (int i = 0; i < 2; i++) begin
      #1 beat("mid", 8'h1B, i, 0, 0);
      tick;
    end
    out_ready = 0;
    #2 reset = 1;
    #1;
    chk("mid_rst_valid", out_valid, 0);
    chk("mid_rst_idx", out_idx, 0);
    chk("mid_rst_data", out_data, 0);
    chk("mid_rst_in_ready", in_ready, 0);
    tick;
    reset = 0;
    #1 idle_chk("mid_release");
    @(negedge clk);
    word("after_rst", 8'hE4, 3'd4, 4);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
